// File: rtl/full_adder_pkg.sv
// Shared constants and the reference sum used by the adder's assertions
// and by anything that needs a golden {cout, s} value.
package full_adder_pkg;

  localparam int WIDTH_MAX = 64;

  // Reference {cout, s} for an adder of the given width. Operand bits above
  // the width are ignored. The result is zero-extended to WIDTH_MAX+1 bits,
  // with cout at bit position `width`.
  function automatic logic [WIDTH_MAX:0] ref_add(
    input logic [WIDTH_MAX-1:0] a,
    input logic [WIDTH_MAX-1:0] b,
    input logic                 cin,
    input int unsigned          width
  );
    logic [WIDTH_MAX:0] mask;
    logic [WIDTH_MAX:0] sum;
    mask = {(WIDTH_MAX+1){1'b1}} >> (WIDTH_MAX - width);
    sum  = {1'b0, a & mask[WIDTH_MAX-1:0]}
         + {1'b0, b & mask[WIDTH_MAX-1:0]}
         + (WIDTH_MAX+1)'(cin);
    return sum & mask;
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder.
// Handshake: there is no valid/ready pair. Every rising clk edge accepts
// a, b and cin, and the matching s, cout and ovf are valid one edge later.
interface full_adder_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (output a, output b, output cin, input s, input cout, input ovf);
  modport slave  (input a, input b, input cin, output s, output cout, output ovf);

endinterface

// File: rtl/full_adder_fa_cell.sv
// One-bit combinational full adder: the ripple cell of full_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry for one bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-out and signed
// overflow. Results appear one clock after the operands are sampled.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  full_adder_if.slave  bus
);

  // Reject widths the ripple chain and reference function do not cover.
  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, WIDTH_MAX);
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_sum;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (c[i]),
      .s  (s_sum[i]),
      .co (c[i+1])
    );
  end

  // Next result: carry out of the MSB, and overflow when the carries into
  // and out of the sign bit disagree (for WIDTH=1 that is cout ^ cin).
  always_comb begin
    s_d    = s_sum;
    cout_d = c[WIDTH];
    ovf_d  = c[WIDTH] ^ c[WIDTH-1];
  end

  // Output registers; reset clears all results and drops the in-flight one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

`ifndef SYNTHESIS
  // Registered {cout, s} must equal the reference sum of the operands
  // sampled on the previous edge whenever that edge was out of reset.
  a_sum_matches_ref : assert property (
    @(posedge clk) !rst |=>
      ((WIDTH_MAX+1)'({bus.cout, bus.s}) ==
       ref_add(WIDTH_MAX'($past(bus.a)), WIDTH_MAX'($past(bus.b)),
               $past(bus.cin), WIDTH))
  );
`endif

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: drives WIDTH=1, 8 and 64 instances in lockstep
// from one reset, pushes each expected {ovf, cout, s} when operands are
// applied and pops it against the registered outputs one cycle later.
module tb_full_adder;
  import full_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1))  if1 ();
  full_adder_if #(.WIDTH(8))  if8 ();
  full_adder_if #(.WIDTH(64)) if64 ();

  full_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  full_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  full_adder #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q1[$];
  logic [127:0] exp_q8[$];
  logic [127:0] exp_q64[$];

  int    n_checks;
  int    n_fail;
  string phase;

  // Next stimulus per instance (index 0: W1, 1: W8, 2: W64).
  logic        st_rst;
  logic [63:0] st_a [3];
  logic [63:0] st_b [3];
  logic        st_c [3];

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected {ovf, cout, s}; ovf taken from operand/result sign bits.
  function automatic logic [127:0] model(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic cin, input int width,
                                         input logic r);
    logic [WIDTH_MAX:0] sum;
    logic [127:0]       res;
    logic               sa, sb, ss;
    if (r) return '0;
    sum = ref_add(a, b, cin, width);
    sa  = a[width-1];
    sb  = b[width-1];
    ss  = sum[width-1];
    res = 128'(sum);
    res[width+1] = (sa == sb) && (ss != sa);
    return res;
  endfunction

  // ---------------- driver ----------------
  // One cycle: compare results of the previous edge, then apply and record
  // the next stimulus.
  task automatic cycle();
    @(negedge clk);
    if (exp_q1.size() > 0)
      check_eq({phase, "_w1"}, 128'({if1.ovf, if1.cout, if1.s}), exp_q1.pop_front());
    if (exp_q8.size() > 0)
      check_eq({phase, "_w8"}, 128'({if8.ovf, if8.cout, if8.s}), exp_q8.pop_front());
    if (exp_q64.size() > 0)
      check_eq({phase, "_w64"}, 128'({if64.ovf, if64.cout, if64.s}), exp_q64.pop_front());
    rst      = st_rst;
    if1.a    = st_a[0][0:0];
    if1.b    = st_b[0][0:0];
    if1.cin  = st_c[0];
    if8.a    = st_a[1][7:0];
    if8.b    = st_b[1][7:0];
    if8.cin  = st_c[1];
    if64.a   = st_a[2];
    if64.b   = st_b[2];
    if64.cin = st_c[2];
    exp_q1.push_back(model(st_a[0], st_b[0], st_c[0], 1, st_rst));
    exp_q8.push_back(model(st_a[1], st_b[1], st_c[1], 8, st_rst));
    exp_q64.push_back(model(st_a[2], st_b[2], st_c[2], 64, st_rst));
  endtask

  task automatic set_zero();
    for (int k = 0; k < 3; k++) begin
      st_a[k] = '0;
      st_b[k] = '0;
      st_c[k] = 1'b0;
    end
  endtask

  task automatic set_random();
    st_a[0] = 64'($urandom_range(0, 1));
    st_b[0] = 64'($urandom_range(0, 1));
    st_c[0] = 1'($urandom_range(0, 1));
    st_a[1] = 64'($urandom_range(0, 255));
    st_b[1] = 64'($urandom_range(0, 255));
    st_c[1] = 1'($urandom_range(0, 1));
    st_a[2] = {$urandom, $urandom};
    st_b[2] = {$urandom, $urandom};
    st_c[2] = 1'($urandom_range(0, 1));
  endtask

  task automatic set_w8(input logic [7:0] a, input logic [7:0] b, input logic c);
    st_a[1] = 64'(a);
    st_b[1] = 64'(b);
    st_c[1] = c;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    phase    = "reset";
    rst      = 1'b1;
    st_rst   = 1'b1;
    set_zero();
    if1.a = '0;  if1.b = '0;  if1.cin = 1'b0;
    if8.a = '0;  if8.b = '0;  if8.cin = 1'b0;
    if64.a = '0; if64.b = '0; if64.cin = 1'b0;

    // Reset held for 10 cycles with zero operands, then 100 ns released.
    repeat (10) cycle();
    st_rst = 1'b0;
    phase  = "post_reset";
    repeat (10) cycle();

    // All eight single-bit combinations; wider instances see randoms.
    phase = "exhaustive";
    for (int i = 0; i < 8; i++) begin
      set_random();
      st_a[0] = 64'(i[2]);
      st_b[0] = 64'(i[1]);
      st_c[0] = i[0];
      cycle();
    end

    // Full-width carry and signed-overflow boundaries at WIDTH=8/64.
    phase = "boundary";
    set_zero();
    set_w8(8'hFF, 8'h00, 1'b1);
    st_a[2] = '1; st_b[2] = '0; st_c[2] = 1'b1;
    cycle();
    set_w8(8'hFF, 8'hFF, 1'b1);
    st_a[2] = '1; st_b[2] = '1; st_c[2] = 1'b1;
    cycle();
    set_w8(8'h7F, 8'h01, 1'b0);
    st_a[2] = 64'h7FFF_FFFF_FFFF_FFFF; st_b[2] = 64'h1; st_c[2] = 1'b0;
    cycle();
    set_w8(8'h80, 8'h80, 1'b0);
    st_a[2] = 64'h8000_0000_0000_0000; st_b[2] = 64'h8000_0000_0000_0000;
    st_c[2] = 1'b0;
    cycle();
    set_w8(8'h00, 8'h00, 1'b0);
    st_a[2] = '0; st_b[2] = '0; st_c[2] = 1'b0;
    cycle();

    // Reset asserted while 8'h12 + 8'h34 is in flight, then the same sum again.
    phase = "midstream_rst";
    set_w8(8'h12, 8'h34, 1'b0);
    cycle();
    st_rst = 1'b1;
    cycle();
    st_rst = 1'b0;
    cycle();

    // Back-to-back random operands on all instances.
    phase = "random";
    for (int i = 0; i < 10000; i++) begin
      set_random();
      cycle();
    end

    // Drain the last pushed result.
    phase = "drain";
    set_zero();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
